slope_det_mc: RTL and testbench

//  Multi-channel, parametrised slope detector fed by comparator (LVDS) sigma-delta bitstreams.
//  Per channel: decimate bitstream -> two adjacent boxcar windows -> window difference vs threshold.

---
 rtl/slope_det_mc.sv | 212 +++++++++++++++++++++
 tb/tb_slope_det_mc.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/slope_det_mc.sv
// slope_det_mc
// Multi-channel slope detector for comparator (LVDS) sigma-delta bitstreams.
// Each channel decimates its bitstream into DECIM-bit count samples. It keeps
// 2*WIN samples of history and compares the newest-WIN window against the
// oldest-WIN window. A per-channel IDLE/FILL/ARMED/HIT state machine latches a
// hit when the window difference exceeds the shared threshold.
//
// Optional feature: define SLOPE_DET_MC_TSTAMP_EN to add a free-running tick
// counter (cleared on arm) and a per-channel hit timestamp. Without the macro,
// tstamp is tied to 0 and everything else behaves identically.
//
// Ports
//   clk64M    sole clock
//   reset     async active-high reset, clears all state
//   enable    0 forces all channels to IDLE and freezes divider/timestamp
//   arm       1-cycle pulse: all channels enter FILL, timestamp cleared
//   comp      comparator bit per channel
//   slope_neg per-channel polarity, 1 = detect falling slope
//   slope     shared unsigned threshold
//   sdm       registered comp (feedback to the external integrators)
//   tick      decimated-sample strobe
//   conv      older-window sum per channel, ch0 in LSBs
//   det       per-channel latched hit
//   hit_any   OR of det
//   tstamp    tick count at hit per channel, ch0 in LSBs
module slope_det_mc #(
  parameter int NCH   = 4,
  parameter int DECIM = 8,
  parameter int WIN   = 4,
  parameter int TS_W  = 16,
  localparam int AW   = $clog2(DECIM + 1),
  localparam int SW   = AW + $clog2(WIN)
) (
  input  logic                clk64M,
  input  logic                reset,
  input  logic                enable,
  input  logic                arm,
  input  logic [NCH-1:0]      comp,
  input  logic [NCH-1:0]      slope_neg,
  input  logic [SW-1:0]       slope,
  output logic [NCH-1:0]      sdm,
  output logic                tick,
  output logic [NCH*SW-1:0]   conv,
  output logic [NCH-1:0]      det,
  output logic                hit_any,
  output logic [NCH*TS_W-1:0] tstamp
);

  localparam int PW = $clog2(DECIM);
  localparam int HL = 2 * WIN;
  localparam int FW = $clog2(HL + 1);

  typedef enum logic [1:0] {IDLE, FILL, ARMED, HIT} state_t;

  logic [PW-1:0] phase;
  logic          wrap;
  logic [FW-1:0] fill_cnt;
  logic          fill_done;
  logic [AW-1:0] acc     [NCH];
  logic [AW-1:0] sample  [NCH];
  logic [AW-1:0] hist    [NCH][HL];
  logic [SW-1:0] new_sum [NCH];
  logic [SW-1:0] old_sum [NCH];
  logic [SW:0]   diff    [NCH];
  logic [NCH-1:0] cond;
  state_t        state    [NCH];
  state_t        state_nx [NCH];
  logic [NCH-1:0] det_nx;

  assign wrap = enable && (phase == PW'(DECIM - 1));

  always_ff @(posedge clk64M or posedge reset) begin
    if (reset) sdm <= '0;
    else       sdm <= comp;
  end

  // tick is high in the cycle after the last phase of a decimation period.
  always_ff @(posedge clk64M or posedge reset) begin
    if (reset) begin
      phase <= '0;
      tick  <= 1'b0;
    end else begin
      tick <= wrap;
      if (enable) phase <= wrap ? '0 : phase + PW'(1);
    end
  end

  always_comb begin
    for (int ch = 0; ch < NCH; ch++) sample[ch] = acc[ch] + AW'(comp[ch]);
  end

  // The sample is pushed at the wrap edge, so the history (and the sums derived
  // from it) already holds the newest sample during the tick cycle.
  // hist[ch][0] is the newest sample.
  always_ff @(posedge clk64M or posedge reset) begin
    if (reset) begin
      for (int ch = 0; ch < NCH; ch++) begin
        acc[ch] <= '0;
        for (int i = 0; i < HL; i++) hist[ch][i] <= '0;
      end
    end else if (enable) begin
      for (int ch = 0; ch < NCH; ch++) begin
        if (wrap) begin
          acc[ch]     <= '0;
          hist[ch][0] <= sample[ch];
          for (int i = 1; i < HL; i++) hist[ch][i] <= hist[ch][i-1];
        end else begin
          acc[ch] <= sample[ch];
        end
      end
    end
  end

  // diff is a two's-complement SW+1 bit value. Its top bit set means a
  // negative difference, which never detects.
  always_comb begin
    conv = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      new_sum[ch] = '0;
      old_sum[ch] = '0;
      for (int i = 0; i < WIN; i++) begin
        new_sum[ch] = new_sum[ch] + SW'(hist[ch][i]);
        old_sum[ch] = old_sum[ch] + SW'(hist[ch][i+WIN]);
      end
      diff[ch] = slope_neg[ch] ? ({1'b0, old_sum[ch]} - {1'b0, new_sum[ch]})
                               : ({1'b0, new_sum[ch]} - {1'b0, old_sum[ch]});
      cond[ch] = !diff[ch][SW] && (diff[ch][SW-1:0] > slope);
      conv[ch*SW +: SW] = old_sum[ch];
    end
  end

  // Shared fill counter: all channels are armed together, so one count of
  // ticks since arm serves every channel.
  always_ff @(posedge clk64M or posedge reset) begin
    if (reset) begin
      fill_cnt <= '0;
    end else if (enable) begin
      if (arm)                              fill_cnt <= '0;
      else if (tick && fill_cnt != FW'(HL)) fill_cnt <= fill_cnt + FW'(1);
    end
  end

  assign fill_done = tick && (fill_cnt == FW'(HL - 1));

  always_ff @(posedge clk64M or posedge reset) begin
    if (reset) begin
      for (int ch = 0; ch < NCH; ch++) state[ch] <= IDLE;
      det     <= '0;
      hit_any <= 1'b0;
    end else begin
      for (int ch = 0; ch < NCH; ch++) state[ch] <= state_nx[ch];
      det     <= det_nx;
      hit_any <= |det_nx;
    end
  end

  // enable=0 beats arm, and arm beats a detection in the same cycle.
  always_comb begin
    for (int ch = 0; ch < NCH; ch++) begin
      state_nx[ch] = state[ch];
      if (!enable) begin
        state_nx[ch] = IDLE;
      end else if (arm) begin
        state_nx[ch] = FILL;
      end else begin
        case (state[ch])
          FILL:    if (fill_done)          state_nx[ch] = ARMED;
          ARMED:   if (tick && cond[ch])   state_nx[ch] = HIT;
          default: ;
        endcase
      end
      det_nx[ch] = (state_nx[ch] == HIT);
    end
  end

`ifdef SLOPE_DET_MC_TSTAMP_EN
  logic [TS_W-1:0] ts_cnt;
  logic [TS_W-1:0] ts_hold [NCH];
  logic [NCH-1:0]  capture;

  always_comb begin
    for (int ch = 0; ch < NCH; ch++)
      capture[ch] = (state[ch] == ARMED) && (state_nx[ch] == HIT);
  end

  always_ff @(posedge clk64M or posedge reset) begin
    if (reset) begin
      ts_cnt <= '0;
    end else if (enable) begin
      if (arm)       ts_cnt <= '0;
      else if (tick) ts_cnt <= ts_cnt + TS_W'(1);
    end
  end

  always_ff @(posedge clk64M or posedge reset) begin
    if (reset) begin
      for (int ch = 0; ch < NCH; ch++) ts_hold[ch] <= '0;
    end else begin
      for (int ch = 0; ch < NCH; ch++)
        if (capture[ch]) ts_hold[ch] <= ts_cnt;
    end
  end

  always_comb begin
    tstamp = '0;
    for (int ch = 0; ch < NCH; ch++) tstamp[ch*TS_W +: TS_W] = ts_hold[ch];
  end
`else
  assign tstamp = '0;
`endif

endmodule

// File: tb/tb_slope_det_mc.sv
// tb_slope_det_mc
// Directed bench for slope_det_mc (NCH=4, DECIM=8, WIN=4, TS_W=4).
// Stimulus drives comp one decimation period at a time, starting on the tick
// cycle. It pushes each expected det change (vector, cycle, timestamp) into a
// queue. A monitor pops and compares whenever det changes.
module tb_slope_det_mc;
  localparam int NCH   = 4;
  localparam int DECIM = 8;
  localparam int WIN   = 4;
  localparam int TS_W  = 4;
  localparam int SW    = $clog2(DECIM + 1) + $clog2(WIN);
`ifdef SLOPE_DET_MC_TSTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  logic clk64M = 1'b0;
  logic reset  = 1'b1;
  logic enable = 1'b1;
  logic arm    = 1'b0;
  logic [NCH-1:0] comp      = '0;
  logic [NCH-1:0] slope_neg = '0;
  logic [SW-1:0]  slope     = '0;
  logic [NCH-1:0]      sdm;
  logic                tick;
  logic [NCH*SW-1:0]   conv;
  logic [NCH-1:0]      det;
  logic                hit_any;
  logic [NCH*TS_W-1:0] tstamp;

  typedef struct {
    logic [NCH-1:0]  det;
    int              cyc;
    int              ch;
    logic [TS_W-1:0] ts;
  } exp_t;

  exp_t expq[$];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [NCH-1:0] prev_det = '0;

  slope_det_mc #(.NCH(NCH), .DECIM(DECIM), .WIN(WIN), .TS_W(TS_W)) dut (
    .clk64M(clk64M), .reset(reset), .enable(enable), .arm(arm),
    .comp(comp), .slope_neg(slope_neg), .slope(slope),
    .sdm(sdm), .tick(tick), .conv(conv), .det(det),
    .hit_any(hit_any), .tstamp(tstamp)
  );

  always #5 clk64M = ~clk64M;

  always @(posedge clk64M) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Timestamp is the tick counter value during the hit tick: n-1 for the n-th
  // tick after arm, truncated to TS_W bits.
  function automatic logic [TS_W-1:0] expTs(input int n);
    return TS_EN ? TS_W'(n) : '0;
  endfunction

  task automatic pushEvent(input logic [NCH-1:0] d, input int c, input int ch, input int n);
    exp_t e;
    e.det = d;
    e.cyc = c;
    e.ch  = ch;
    e.ts  = expTs(n);
    expq.push_back(e);
  endtask

  always @(posedge clk64M) begin
    exp_t e;
    #1;
    if (reset) begin
      prev_det = '0;
    end else if (det !== prev_det) begin
      if (expq.size() == 0) begin
        checkOutput("unexpected_det", det, prev_det);
      end else begin
        e = expq.pop_front();
        checkOutput("det", det, e.det);
        checkOutput("det_cycle", cyc, e.cyc);
        checkOutput("hit_any", hit_any, |e.det);
        if (e.ch >= 0) checkOutput("tstamp", tstamp[e.ch*TS_W +: TS_W], e.ts);
      end
      prev_det = det;
    end
  end

  // Holds comp for n whole decimation periods, starting and ending at the
  // negedge of a tick cycle.
  task automatic applyStimulus(input int n, input logic [NCH-1:0] val);
    comp = val;
    repeat (n * DECIM) @(negedge clk64M);
  endtask

  task automatic armPeriod(input logic [NCH-1:0] val);
    comp = val;
    arm  = 1'b1;
    @(negedge clk64M);
    arm  = 1'b0;
    repeat (DECIM - 1) @(negedge clk64M);
  endtask

  task automatic alignTick();
    int k = 0;
    while (tick !== 1'b1 && k < 4 * DECIM) begin
      @(negedge clk64M);
      k++;
    end
    if (tick !== 1'b1) checkOutput("tick_timeout", tick, 1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_sdm"},     sdm,     0);
    checkOutput({tag, "_tick"},    tick,    0);
    checkOutput({tag, "_conv"},    conv,    0);
    checkOutput({tag, "_det"},     det,     0);
    checkOutput({tag, "_hit_any"}, hit_any, 0);
    checkOutput({tag, "_tstamp"},  tstamp,  0);
  endtask

  task automatic doReset();
    @(negedge clk64M);
    reset = 1'b1;
    comp = '0;
    arm = 1'b0;
    enable = 1'b1;
    @(negedge clk64M);
    reset = 1'b0;
    alignTick();
  endtask

  initial begin
    int a;
    repeat (3) @(negedge clk64M);
    checkResetOutputs("init");
    reset = 1'b0;
    alignTick();

    // Rising step on ch0 after 8 zero periods, slope 10: hit at tick 10 (diff 16).
    doReset();
    slope = 6'd10;
    slope_neg = '0;
    a = cyc;
    pushEvent(4'b0001, a + 81, 0, 9);
    armPeriod(4'b0000);
    applyStimulus(7, 4'b0000);
    applyStimulus(6, 4'b0001);
    checkOutput("conv_s2", conv, {6'd0, 6'd0, 6'd0, 6'd16});
    checkOutput("tick_s2", tick, 1);
    checkOutput("sdm_s2", sdm, 4'b0001);

    // Re-arm from HIT clears det. Then reset mid-FILL with all comp bits high.
    a = cyc;
    pushEvent(4'b0000, a + 1, -1, 0);
    armPeriod(4'b1111);
    applyStimulus(2, 4'b1111);
    reset = 1'b1;
    @(negedge clk64M);
    checkResetOutputs("mid_fill");
    reset = 1'b0;
    applyStimulus(12, 4'b1111);
    checkOutput("det_after_reset", det, 0);

    // ch0 falling polarity, ch1 rising polarity on the same 0->1->0 pulse.
    doReset();
    slope = 6'd10;
    slope_neg = 4'b0001;
    a = cyc;
    pushEvent(4'b0010, a + 81, 1, 9);
    pushEvent(4'b0011, a + 145, 0, 17);
    armPeriod(4'b0000);
    applyStimulus(7, 4'b0000);
    applyStimulus(8, 4'b0011);
    applyStimulus(4, 4'b0000);
    checkOutput("det_s3", det, 4'b0011);
    checkOutput("tstamp_s3", tstamp, {TS_W'(0), TS_W'(0), expTs(9), expTs(17)});

    // Steps during FILL. ch0 hits at the first ARMED tick (diff 24 > 16);
    // ch2 sees diff == slope and must not hit.
    doReset();
    slope = 6'd16;
    slope_neg = '0;
    a = cyc;
    pushEvent(4'b0001, a + 73, 0, 8);
    armPeriod(4'b0000);
    applyStimulus(2, 4'b0000);
    applyStimulus(1, 4'b0100);
    applyStimulus(8, 4'b0101);
    checkOutput("conv_s4", conv, {6'd0, 6'd32, 6'd0, 6'd32});

    // enable=0 while in HIT, just before a wrap: det drops, no tick while frozen.
    repeat (DECIM - 1) @(negedge clk64M);
    a = cyc;
    pushEvent(4'b0000, a + 1, -1, 0);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk64M);
      checkOutput("tick_frozen", tick, 0);
    end
    checkOutput("hit_any_disabled", hit_any, 0);
    arm = 1'b1;
    @(negedge clk64M);
    arm = 1'b0;
    @(negedge clk64M);
    enable = 1'b1;
    alignTick();
    applyStimulus(4, 4'b0000);
    applyStimulus(6, 4'b0001);
    checkOutput("det_idle", det, 0);

    // arm on the very tick a hit would latch: arm wins, no det afterwards.
    doReset();
    slope = 6'd10;
    slope_neg = '0;
    armPeriod(4'b0000);
    applyStimulus(7, 4'b0000);
    applyStimulus(2, 4'b0001);
    armPeriod(4'b0001);
    applyStimulus(12, 4'b0001);
    checkOutput("det_arm_wins", det, 0);
    checkOutput("hit_any_arm_wins", hit_any, 0);

    repeat (4) @(negedge clk64M);
    checkOutput("events_pending", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
